// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 16-bit CPU: fetch/decode/execute/memory/writeback sequencing.
// Latency: 3-4 cycles per instruction plus one cycle per mem_ready=0 cycle in a memory state.
// Backpressure: memory states hold mem_req until mem_ready; WAIT_LIMIT stalled cycles -> sticky FAULT.
module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic [3:0] opext,
    input  logic       cond_true,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic [1:0] pcsrc,
    output logic       regwrite,
    output logic       memtoreg,
    output logic [1:0] alusrcb,
    output logic       flagwrite,
    output logic       fault,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_WB_ALU = 4'd4,
        S_MEM_RD = 4'd5,
        S_WB_LD  = 4'd6,
        S_MEM_WR = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_CMP    = 4'd10,
        S_FAULT  = 4'd15
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // B-operand select and flag-update request captured at DECODE, held through execute/writeback
    logic [1:0]       srcb_q, srcb_d;
    logic             flag_q, flag_d;

    logic             mem_state;
    logic             timeout;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // The last allowed stalled cycle is the one where the counter already shows WAIT_LIMIT-1;
    // a mem_ready on that same cycle still wins.
    assign timeout   = mem_state && !mem_ready && (cnt_q == CNT_LAST);

    // Next-state, wait-counter and decode-latch logic
    always_comb begin
        state_d = state_q;
        srcb_d  = srcb_q;
        flag_d  = flag_q;
        cnt_d   = '0;
        if (mem_state && !mem_ready && !timeout) begin
            cnt_d = cnt_q + CNT_ONE;
        end
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
                      else if (timeout) state_d = S_FAULT;
            S_DECODE: begin
                srcb_d  = 2'b00;
                flag_d  = 1'b0;
                state_d = S_FAULT;
                case (opcode)
                    4'b0000: begin
                        case (opext)
                            4'b0101, 4'b1001: begin state_d = S_EXEC_R; flag_d = 1'b1; end
                            4'b0001, 4'b0010, 4'b0011, 4'b1101: state_d = S_EXEC_R;
                            4'b1011: state_d = S_CMP;
                            default: state_d = S_FAULT;
                        endcase
                    end
                    4'b0101, 4'b1001: begin state_d = S_EXEC_I; srcb_d = 2'b01; flag_d = 1'b1; end
                    4'b1101:          begin state_d = S_EXEC_I; srcb_d = 2'b01; end
                    4'b0001, 4'b0010, 4'b0011: begin state_d = S_EXEC_I; srcb_d = 2'b10; end
                    4'b1111:          begin state_d = S_EXEC_I; srcb_d = 2'b11; end
                    4'b1011:          begin state_d = S_CMP;    srcb_d = 2'b01; end
                    4'b0100: begin
                        case (opext)
                            4'b0000: state_d = S_MEM_RD;
                            4'b0100: state_d = S_MEM_WR;
                            4'b1100: state_d = S_JUMP;
                            default: state_d = S_FAULT;
                        endcase
                    end
                    4'b1100: state_d = S_BRANCH;
                    default: state_d = S_FAULT;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_WB_ALU, S_WB_LD, S_BRANCH, S_JUMP, S_CMP: state_d = S_FETCH;
            S_MEM_RD: if (mem_ready) state_d = S_WB_LD;
                      else if (timeout) state_d = S_FAULT;
            S_MEM_WR: if (mem_ready) state_d = S_FETCH;
                      else if (timeout) state_d = S_FAULT;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase
    end

    // State, wait counter and decode latches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            srcb_q  <= 2'b00;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            srcb_q  <= srcb_d;
            flag_q  <= flag_d;
        end
    end

    // Moore output decode; gated by reset so an in-flight request drops the moment reset asserts
    always_comb begin
        mem_req   = 1'b0;
        memwrite  = 1'b0;
        iord      = 1'b0;
        irwrite   = 1'b0;
        pcwrite   = 1'b0;
        pcsrc     = 2'b00;
        regwrite  = 1'b0;
        memtoreg  = 1'b0;
        alusrcb   = 2'b00;
        flagwrite = 1'b0;
        fault     = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    // PC and IR always update together on fetch completion
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_EXEC_R, S_EXEC_I: begin
                    alusrcb   = srcb_q;
                    flagwrite = flag_q;
                end
                S_WB_ALU: begin
                    regwrite = 1'b1;
                    alusrcb  = srcb_q;
                end
                S_CMP: begin
                    flagwrite = 1'b1;
                    alusrcb   = srcb_q;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_WB_LD: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                S_BRANCH: begin
                    pcsrc   = 2'b01;
                    pcwrite = cond_true;
                end
                S_JUMP: begin
                    pcsrc   = 2'b10;
                    pcwrite = cond_true;
                end
                S_FAULT: fault = 1'b1;
                default: fault = 1'b0;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a short wait limit so timeouts are reachable.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// Expected output vectors are written out by hand per step.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode, opext;
    logic       cond_true, mem_ready;
    logic       mem_req, memwrite, iord, irwrite, pcwrite;
    logic [1:0] pcsrc, alusrcb;
    logic       regwrite, memtoreg, flagwrite, fault;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_ctrl #(.WAIT_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .opext(opext),
        .cond_true(cond_true), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .pcwrite(pcwrite), .pcsrc(pcsrc), .regwrite(regwrite), .memtoreg(memtoreg),
        .alusrcb(alusrcb), .flagwrite(flagwrite), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {state, mem_req, memwrite, iord, irwrite, pcwrite, pcsrc,
                  regwrite, memtoreg, alusrcb, flagwrite, fault};

    // Field order: state, mem_req, memwrite, iord, irwrite, pcwrite, pcsrc, regwrite, memtoreg, alusrcb, flagwrite, fault
    function automatic logic [16:0] ev(input logic [3:0] st, input logic rq, input logic mw,
                                       input logic io, input logic irw, input logic pcw,
                                       input logic [1:0] ps, input logic rw, input logic m2r,
                                       input logic [1:0] sb, input logic fw, input logic flt);
        return {st, rq, mw, io, irw, pcw, ps, rw, m2r, sb, fw, flt};
    endfunction

    task automatic chk(input string tag, input logic [16:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check this cycle's outputs, then advance to the next falling edge
    task automatic cyc(input string tag, input logic [16:0] exp);
        #1;
        chk(tag, exp);
        @(negedge clk);
    endtask

    task automatic fetch_ok(input string tag);
        mem_ready = 1'b1;
        cyc(tag, ev(4'd0, 1,0,0,1,1, 2'b00, 0,0, 2'b00, 0,0));
    endtask

    task automatic decode(input string tag);
        cyc(tag, ev(4'd1, 0,0,0,0,0, 2'b00, 0,0, 2'b00, 0,0));
    endtask

    task automatic do_reset;
        reset = 1'b0;
        #1;
        chk("reset_outputs", ev(4'd0, 0,0,0,0,0, 2'b00, 0,0, 2'b00, 0,0));
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; opcode = 4'h0; opext = 4'h0; cond_true = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("reset_state", ev(4'd0, 0,0,0,0,0, 2'b00, 0,0, 2'b00, 0,0));
        reset = 1'b1;

        // ADD R1,R2 (0x0152)
        opcode = 4'h0; opext = 4'h5;
        fetch_ok("add_fetch");
        decode("add_decode");
        cyc("add_exec", ev(4'd2, 0,0,0,0,0, 2'b00, 0,0, 2'b00, 1,0));
        cyc("add_wb",   ev(4'd4, 0,0,0,0,0, 2'b00, 1,0, 2'b00, 0,0));

        // AND (register, no flags)
        opcode = 4'h0; opext = 4'h1;
        fetch_ok("and_fetch");
        decode("and_decode");
        cyc("and_exec", ev(4'd2, 0,0,0,0,0, 2'b00, 0,0, 2'b00, 0,0));
        cyc("and_wb",   ev(4'd4, 0,0,0,0,0, 2'b00, 1,0, 2'b00, 0,0));

        // ADDI: sign-extended immediate, flags updated
        opcode = 4'h5; opext = 4'h3;
        fetch_ok("addi_fetch");
        decode("addi_decode");
        cyc("addi_exec", ev(4'd3, 0,0,0,0,0, 2'b00, 0,0, 2'b01, 1,0));
        cyc("addi_wb",   ev(4'd4, 0,0,0,0,0, 2'b00, 1,0, 2'b01, 0,0));

        // ORI: zero-extended immediate, no flags
        opcode = 4'h2; opext = 4'h7;
        fetch_ok("ori_fetch");
        decode("ori_decode");
        cyc("ori_exec", ev(4'd3, 0,0,0,0,0, 2'b00, 0,0, 2'b10, 0,0));
        cyc("ori_wb",   ev(4'd4, 0,0,0,0,0, 2'b00, 1,0, 2'b10, 0,0));

        // LUI: imm8<<8 select
        opcode = 4'hF; opext = 4'h0;
        fetch_ok("lui_fetch");
        decode("lui_decode");
        cyc("lui_exec", ev(4'd3, 0,0,0,0,0, 2'b00, 0,0, 2'b11, 0,0));
        cyc("lui_wb",   ev(4'd4, 0,0,0,0,0, 2'b00, 1,0, 2'b11, 0,0));

        // CMP (register) and CMPI
        opcode = 4'h0; opext = 4'hB;
        fetch_ok("cmp_fetch");
        decode("cmp_decode");
        cyc("cmp_exec", ev(4'd10, 0,0,0,0,0, 2'b00, 0,0, 2'b00, 1,0));
        opcode = 4'hB; opext = 4'h2;
        fetch_ok("cmpi_fetch");
        decode("cmpi_decode");
        cyc("cmpi_exec", ev(4'd10, 0,0,0,0,0, 2'b00, 0,0, 2'b01, 1,0));

        // LOAD (0x4300) with 3 stalled cycles; ready on the counter's last allowed cycle
        opcode = 4'h4; opext = 4'h0;
        fetch_ok("ld_fetch");
        decode("ld_decode");
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("ld_memrd_wait", ev(4'd5, 1,0,1,0,0, 2'b00, 0,0, 2'b00, 0,0));
        mem_ready = 1'b1;
        cyc("ld_memrd_done", ev(4'd5, 1,0,1,0,0, 2'b00, 0,0, 2'b00, 0,0));
        cyc("ld_wb",         ev(4'd6, 0,0,0,0,0, 2'b00, 1,1, 2'b00, 0,0));

        // STORE with ready immediately
        opcode = 4'h4; opext = 4'h4;
        fetch_ok("st_fetch");
        decode("st_decode");
        cyc("st_memwr", ev(4'd7, 1,1,1,0,0, 2'b00, 0,0, 2'b00, 0,0));

        // Branch 0xC0FE taken, then not taken
        opcode = 4'hC; opext = 4'hF; cond_true = 1'b1;
        fetch_ok("br_t_fetch");
        decode("br_t_decode");
        cyc("br_taken", ev(4'd8, 0,0,0,0,1, 2'b01, 0,0, 2'b00, 0,0));
        cond_true = 1'b0;
        fetch_ok("br_n_fetch");
        decode("br_n_decode");
        cyc("br_not_taken", ev(4'd8, 0,0,0,0,0, 2'b01, 0,0, 2'b00, 0,0));

        // Jump taken
        opcode = 4'h4; opext = 4'hC; cond_true = 1'b1;
        fetch_ok("jmp_fetch");
        decode("jmp_decode");
        cyc("jmp_taken", ev(4'd9, 0,0,0,0,1, 2'b10, 0,0, 2'b00, 0,0));
        cond_true = 1'b0;

        // Undefined opcode 0xE000 -> FAULT, terminal for 20 cycles
        opcode = 4'hE; opext = 4'h0;
        fetch_ok("ill_fetch");
        decode("ill_decode");
        for (int i = 0; i < 20; i++) cyc("ill_fault", ev(4'd15, 0,0,0,0,0, 2'b00, 0,0, 2'b00, 0,1));
        do_reset();

        // Fetch timeout: 4 stalled cycles then FAULT
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc("to_fetch_wait", ev(4'd0, 1,0,0,0,0, 2'b00, 0,0, 2'b00, 0,0));
        cyc("to_fault", ev(4'd15, 0,0,0,0,0, 2'b00, 0,0, 2'b00, 0,1));
        do_reset();

        // Ready on the 4th cycle counts as success
        opcode = 4'h0; opext = 4'h5;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("edge_fetch_wait", ev(4'd0, 1,0,0,0,0, 2'b00, 0,0, 2'b00, 0,0));
        fetch_ok("edge_fetch_done");
        decode("edge_decode");

        // Reset asserted mid-MEM_WR: request drops asynchronously
        cyc("edge_exec", ev(4'd2, 0,0,0,0,0, 2'b00, 0,0, 2'b00, 1,0));
        cyc("edge_wb",   ev(4'd4, 0,0,0,0,0, 2'b00, 1,0, 2'b00, 0,0));
        opcode = 4'h4; opext = 4'h4;
        fetch_ok("rst_fetch");
        decode("rst_decode");
        mem_ready = 1'b0;
        #1;
        chk("rst_memwr", ev(4'd7, 1,1,1,0,0, 2'b00, 0,0, 2'b00, 0,0));
        #1;
        reset = 1'b0;
        #1;
        chk("rst_async_drop", ev(4'd0, 0,0,0,0,0, 2'b00, 0,0, 2'b00, 0,0));
        @(negedge clk);
        reset = 1'b1;
        cyc("rst_release_fetch", ev(4'd0, 1,0,0,0,0, 2'b00, 0,0, 2'b00, 0,0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
